// File: rtl/fpu_add_issue_if.sv
// Bus bundle between the fp16 add-issue block, its operand producer, the
// external adder and the result consumer. The slave modport is the issue block.
interface fpu_add_issue_if #(
  parameter int DEPTH = 4
);
  logic [15:0]              in_a;
  logic [15:0]              in_b;
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              fpu_a;
  logic [31:0]              fpu_b;
  logic                     fpu_valid;
  logic [31:0]              fpu_result;
  logic                     fpu_done;
  logic [15:0]              res_data;
  logic                     res_valid;
  logic                     res_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     busy;
  logic                     timeout_err;

  modport slave (
    input  in_a, in_b, in_valid, fpu_result, fpu_done, res_ready,
    output in_ready, fpu_a, fpu_b, fpu_valid, res_data, res_valid,
           count, busy, timeout_err
  );

  modport master (
    output in_a, in_b, in_valid, fpu_result, fpu_done, res_ready,
    input  in_ready, fpu_a, fpu_b, fpu_valid, res_data, res_valid,
           count, busy, timeout_err
  );
endinterface

// File: rtl/fpu_add_issue.sv
// fp16 add issue unit: buffers operand pairs in a small circular FIFO and
// feeds them one at a time to an external pipelined adder, holding each sum
// until the consumer takes it. Only one operation is ever outstanding.
// Optional feature: define FPU_ISSUE_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles, returning the NaN pattern 16'h7C01 and a sticky error flag.
module fpu_add_issue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  fpu_add_issue_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state_q, state_d;

  logic [31:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           push, pop;
  logic [31:0]    head;

  logic           fpu_valid_q, fpu_valid_d;
  logic [15:0]    fpu_a_q, fpu_a_d;
  logic [15:0]    fpu_b_q, fpu_b_d;
  logic [15:0]    res_data_q, res_data_d;
  logic           res_valid_q, res_valid_d;

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]  timer_q, timer_d;
  logic           timeout_err_q, timeout_err_d;
`else
  logic [31:0]    unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  // Upper half of the adder result is not part of the fp16 sum.
  logic           unused_result_hi;
  assign unused_result_hi = ^bus.fpu_result[31:16];

  // Ready depends only on occupancy, so a full FIFO never accepts even if
  // the head is popped in the same cycle.
  assign bus.in_ready = (count_q < CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign head         = mem_q[rd_ptr_q];

  // Operand storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
    end
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Issue FSM next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    fpu_valid_d = 1'b0;
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
`ifdef FPU_ISSUE_TIMEOUT_EN
    timer_d       = timer_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          fpu_a_d     = head[31:16];
          fpu_b_d     = head[15:0];
          fpu_valid_d = 1'b1;
          state_d     = WAIT;
`ifdef FPU_ISSUE_TIMEOUT_EN
          timer_d     = '0;
`endif
        end
      end
      WAIT: begin
        if (bus.fpu_done) begin
          res_data_d  = bus.fpu_result[15:0];
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
`ifdef FPU_ISSUE_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_data_d    = 16'h7C01;
          res_valid_d   = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = HOLD;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fpu_valid_q <= 1'b0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fpu_valid_q <= fpu_valid_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef FPU_ISSUE_TIMEOUT_EN
  // WAIT timer and sticky abort flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.fpu_a     = {16'h0000, fpu_a_q};
  assign bus.fpu_b     = {16'h0000, fpu_b_q};
  assign bus.fpu_valid = fpu_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_valid = res_valid_q;
  assign bus.count     = count_q;
  assign bus.busy      = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_fpu_add_issue.sv
// Directed bench for fpu_add_issue with a 6-stage table-driven fp16 adder.
module tb_fpu_add_issue;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpu_add_issue_if #(.DEPTH(4)) bus();

  fpu_add_issue #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Hand-computed fp16 sums for the pairs used below.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_3C00: ref_add = 16'h4000;  // 1 + 1 = 2
      32'h4000_BC00: ref_add = 16'h3C00;  // 2 - 1 = 1
      32'h7C00_FC00: ref_add = 16'h7C01;  // inf - inf = NaN
      32'h4000_4000: ref_add = 16'h4400;  // 2 + 2 = 4
      32'h4400_4400: ref_add = 16'h4800;  // 4 + 4 = 8
      32'h3C00_4000: ref_add = 16'h4200;  // 1 + 2 = 3
      default:       ref_add = 16'h7E00;
    endcase
  endfunction

  // External adder: 6 pipeline stages, never reset.
  logic        adder_en = 1'b1;
  logic [5:0]  pv = '0;
  logic [15:0] pd [6];
  always @(posedge clk) begin
    pv    <= {pv[4:0], bus.fpu_valid};
    pd[0] <= ref_add(bus.fpu_a[15:0], bus.fpu_b[15:0]);
    for (int k = 1; k < 6; k++) pd[k] <= pd[k-1];
  end
  assign bus.fpu_done   = pv[5] & adder_en;
  assign bus.fpu_result = {16'h0000, pd[5]};

  // Observe issue pulses, result transfers and peak occupancy.
  int          issue_cnt = 0;
  int          max_cnt   = 0;
  logic [15:0] res_q[$];
  always @(negedge clk) begin
    if (bus.fpu_valid === 1'b1) issue_cnt++;
    if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) res_q.push_back(bus.res_data);
    if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res(input string tag, input int n, input int lim);
    int w;
    w = 0;
    while (res_q.size() < n && w < lim) begin
      tick();
      w++;
    end
    chk(tag, res_q.size(), n);
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    int w;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) chk("push_ready_timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  logic [15:0] exp3 [3];
  logic [15:0] exp5 [5];
  logic [15:0] held;
  int          i0, bad;

  initial begin
    rst_n         = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    chk("rst_fpu_valid", bus.fpu_valid, 0);
    chk("rst_fpu_a", bus.fpu_a, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    rst_n = 1'b1;
    tick();

    // Single 1+1 with latency: issue after edge 1, result after edge 8.
    bus.res_ready = 1'b1;
    bus.in_a = 16'h3C00; bus.in_b = 16'h3C00; bus.in_valid = 1'b1;
    tick();                                   // edge 0
    bus.in_valid = 1'b0;
    chk("lat_count_e0", bus.count, 1);
    chk("lat_fpu_valid_e0", bus.fpu_valid, 0);
    tick();                                   // edge 1
    chk("lat_fpu_valid_e1", bus.fpu_valid, 1);
    chk("lat_fpu_a_e1", bus.fpu_a, 32'h0000_3C00);
    chk("lat_fpu_b_e1", bus.fpu_b, 32'h0000_3C00);
    chk("lat_count_e1", bus.count, 0);
    chk("lat_busy_e1", bus.busy, 1);
    for (int e = 2; e <= 7; e++) begin
      tick();
      chk($sformatf("lat_res_valid_e%0d", e), bus.res_valid, 0);
      if (e == 2) chk("lat_fpu_valid_e2", bus.fpu_valid, 0);
    end
    tick();                                   // edge 8
    chk("lat_res_valid_e8", bus.res_valid, 1);
    chk("lat_res_data_e8", bus.res_data, 16'h4000);
    chk("lat_fpu_a_hold", bus.fpu_a, 32'h0000_3C00);
    tick();                                   // edge 9
    chk("lat_res_valid_e9", bus.res_valid, 0);
    chk("lat_busy_e9", bus.busy, 0);

    // Three pairs in order, including inf - inf.
    res_q.delete();
    i0 = issue_cnt;
    exp3[0] = 16'h3C00; exp3[1] = 16'h4000; exp3[2] = 16'h7C01;
    push_pair(16'h4000, 16'hBC00);
    push_pair(16'h3C00, 16'h3C00);
    push_pair(16'h7C00, 16'hFC00);
    wait_res("seq3_count", 3, 60);
    if (res_q.size() >= 3)
      for (int i = 0; i < 3; i++) chk($sformatf("seq3_res%0d", i), res_q[i], exp3[i]);
    tick();
    chk("seq3_issues", issue_cnt - i0, 3);

    // Fill the FIFO with the consumer stalled, then hold for 20 cycles.
    res_q.delete();
    bus.res_ready = 1'b0;
    i0      = issue_cnt;
    max_cnt = 0;
    exp5[0] = 16'h4000; exp5[1] = 16'h4400; exp5[2] = 16'h4800;
    exp5[3] = 16'h4200; exp5[4] = 16'h3C00;
    push_pair(16'h3C00, 16'h3C00);
    push_pair(16'h4000, 16'h4000);
    push_pair(16'h4400, 16'h4400);
    push_pair(16'h3C00, 16'h4000);
    push_pair(16'h4000, 16'hBC00);
    chk("full_count", bus.count, 4);
    chk("full_in_ready", bus.in_ready, 0);
    bus.in_a = 16'h3C00; bus.in_b = 16'h3C00; bus.in_valid = 1'b1;
    bad = 0;
    while (!bus.res_valid && bad < 30) begin
      tick();
      bad++;
    end
    chk("hold_res_valid", bus.res_valid, 1);
    held = bus.res_data;
    chk("hold_res_data", held, 16'h4000);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.res_valid !== 1'b1 || bus.res_data !== held || bus.count !== 3'd4) bad++;
    end
    chk("hold_stable", bad, 0);
    chk("hold_issues", issue_cnt - i0, 1);
    chk("hold_max_count", max_cnt, 4);
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    wait_res("drain_count", 5, 100);
    if (res_q.size() >= 5)
      for (int i = 0; i < 5; i++) chk($sformatf("drain_res%0d", i), res_q[i], exp5[i]);
    tick();
    chk("drain_issues", issue_cnt - i0, 5);
    chk("drain_max_count", max_cnt, 4);

    // Reset while WAITing with two entries queued.
    push_pair(16'h4000, 16'h4000);
    push_pair(16'h4400, 16'h4400);
    push_pair(16'h3C00, 16'h3C00);
    chk("mid_count", bus.count, 2);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_fpu_valid", bus.fpu_valid, 0);
    chk("mid_rst_fpu_a", bus.fpu_a, 0);
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    res_q.delete();
    i0  = issue_cnt;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.res_valid !== 1'b0) bad++;
    end
    chk("late_done_res_valid", bad, 0);
    chk("late_done_results", res_q.size(), 0);
    chk("late_done_issues", issue_cnt - i0, 0);
    chk("late_done_busy", bus.busy, 0);

    // Adder that never answers.
    adder_en = 1'b0;
    bus.in_a = 16'h3C00; bus.in_b = 16'h3C00; bus.in_valid = 1'b1;
    tick();                                   // edge 0
    bus.in_valid = 1'b0;
    for (int e = 1; e <= 15; e++) tick();
    chk("to_res_valid_e15", bus.res_valid, 0);
    chk("to_busy_e15", bus.busy, 1);
`ifdef FPU_ISSUE_TIMEOUT_EN
    tick();                                   // edge 16
    chk("to_res_valid_e16", bus.res_valid, 1);
    chk("to_res_data_e16", bus.res_data, 16'h7C01);
    chk("to_err_e16", bus.timeout_err, 1);
    tick();
    chk("to_res_valid_after", bus.res_valid, 0);
    chk("to_err_sticky", bus.timeout_err, 1);
    chk("to_busy_after", bus.busy, 0);
`else
    for (int e = 0; e < 15; e++) tick();
    chk("nto_res_valid", bus.res_valid, 0);
    chk("nto_busy", bus.busy, 1);
    chk("nto_err", bus.timeout_err, 0);
`endif
    rst_n = 1'b0;
    tick();
    chk("final_rst_err", bus.timeout_err, 0);
    chk("final_rst_busy", bus.busy, 0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fpu_add_issue.md
FPU_ADD_ISSUE -- requirements
Module: fpu_add_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT, default 15, cycles in WAIT before abort (used only with FPU_ISSUE_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_a  input  16  fp16 operand A from the bus.
REQ-006 SHALL have port in_b  input  16  fp16 operand B from the bus.
REQ-007 SHALL have port in_valid  input  1  operand pair present.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept; push occurs when in_valid && in_ready.
REQ-009 SHALL have port fpu_a  output  32  to adder a; {16'b0, head A}.
REQ-010 SHALL have port fpu_b  output  32  to adder b; {16'b0, head B}.
REQ-011 SHALL have port fpu_valid  output  1  one-cycle registered issue pulse to adder valid_in.
REQ-012 SHALL have port fpu_result  input  32  adder result; bits [15:0] used.
REQ-013 SHALL have port fpu_done  input  1  adder valid_out.
REQ-014 SHALL have port res_data  output  16  held fp16 sum.
REQ-015 SHALL have port res_valid  output  1  res_data valid.
REQ-016 SHALL have port res_ready  input  1  consumer accepts; transfer when res_valid && res_ready.
REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-018 SHALL have port busy  output  1  high when state != IDLE or count != 0.
REQ-019 SHALL have port timeout_err  output  1  sticky abort flag.

Function
REQ-020 FIFO SHALL be circular, DEPTH x 32 bits {A,B}, with wrapping read/write pointers and a separate count.
REQ-021 in_ready SHALL equal (count < DEPTH), independent of a same-cycle pop; a push while full SHALL NOT occur.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-023 FSM states SHALL be IDLE, WAIT, HOLD; only one operation outstanding at the adder.
REQ-024 IDLE with count>0: at the next edge, fpu_a/fpu_b <= head, fpu_valid <= 1, pop head, go WAIT.
REQ-025 fpu_valid SHALL be high for exactly one cycle per issue; fpu_a/fpu_b hold their value until the next issue.
REQ-026 WAIT with fpu_done: res_data <= fpu_result[15:0], res_valid <= 1, go HOLD.
REQ-027 HOLD with res_ready: res_valid <= 0, go IDLE; no issue in the same edge.
REQ-028 fpu_done outside WAIT SHALL be ignored.
REQ-029 With a 6-stage adder, a push at edge 0 into an empty idle block SHALL give fpu_valid after edge 1 and res_valid after edge 8.
REQ-030 Results SHALL emerge in push order; no value is altered by this block.

Reset
REQ-031 While rst_n low: state IDLE, pointers and count 0, fpu_valid 0, fpu_a/fpu_b 0, res_data 0, res_valid 0, timeout_err 0, timer 0.
REQ-032 Reset mid-operation SHALL discard FIFO contents and any in-flight result; a later fpu_done SHALL be ignored per REQ-028.

Configuration
REQ-033 Macro FPU_ISSUE_TIMEOUT_EN defined: WAIT timer counts cycles since issue; if TIMEOUT cycles elapse without fpu_done, res_data <= 16'h7C01, res_valid <= 1, timeout_err <= 1 (sticky until reset), go HOLD.
REQ-034 Macro undefined: no timer logic; WAIT lasts until fpu_done; timeout_err tied 0.

Verification
REQ-035 Push (3C00,3C00) into idle block with real adder, res_ready=1 -> fpu_valid after edge 1, res_valid after edge 8 with res_data=16'h4000.
REQ-036 Push 5 pairs back-to-back with DEPTH=4, res_ready=0 -> in_ready low when count=4; fifth accepted only after first pop; count never exceeds 4.
REQ-037 Push (4000,BC00),(3C00,3C00),(7C00,FC00) -> res_data sequence 3C00, 4000, 7C01 in order, one fpu_valid pulse each.
REQ-038 Hold res_ready=0 for 20 cycles after a result -> res_valid and res_data stable, no further fpu_valid pulse, then res_ready=1 -> next issue follows.
REQ-039 Assert rst_n low in WAIT with 2 entries queued -> all outputs reset values, count=0, late fpu_done produces no res_valid.
REQ-040 With FPU_ISSUE_TIMEOUT_EN, stub adder never asserts fpu_done -> after 15 WAIT cycles res_data=7C01, res_valid=1, timeout_err=1 and stays 1; without macro, block stays in WAIT.
